// File: rtl/mire_pkg.sv
// Shared types and constants for the test-pattern frame writer.
// Holds the writer FSM state encoding, pattern colours and Wishbone cycle-type codes.
package mire_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [15:0] WHITE = 16'hFFFF;
  localparam logic [15:0] BLACK = 16'h0000;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // True when v is a multiple of 2**log2.
  function automatic logic on_grid(input logic [31:0] v, input int unsigned log2);
    logic [31:0] mask;
    mask = (32'd1 << log2) - 32'd1;
    return (v & mask) == 32'd0;
  endfunction

endpackage

// File: rtl/mire_writer_pixel_scan_counter.sv
// Raster x/y counter: x wraps at HDISP-1 and bumps y, y wraps at VDISP-1.
// Latency: one cycle from inc to updated x/y; backpressure: advances only on inc.
// 'last' flags the bottom-right pixel combinationally.
module pixel_scan_counter
  import mire_pkg::*;
#(
  parameter int HDISP = 640,
  parameter int VDISP = 480,
  parameter int XW    = cnt_width(HDISP),
  parameter int YW    = cnt_width(VDISP)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);

  localparam logic [XW-1:0] X_MAX = XW'(HDISP - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(VDISP - 1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      x <= '0;
      y <= '0;
    end else if (inc) begin
      if (x == X_MAX) begin
        x <= '0;
        y <= (y == Y_MAX) ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  assign last = (x == X_MAX) && (y == Y_MAX);

endmodule

// File: rtl/mire_writer.sv
// Wishbone master writing a grid test pattern (RGB565) into the frame buffer; MIRE_CONTINUOUS_EN loops frames forever.
// Latency: cyc/stb rise one cycle after start; one pixel per ack/err, with a one-cycle bus release every BURST_LEN writes.
// Backpressure: stb, adr and data hold until the slave acks or errs; no retry on err.
module mire_writer
  import mire_pkg::*;
#(
  parameter int          HDISP     = 640,
  parameter int          VDISP     = 480,
  parameter int          BURST_LEN = 64,
  parameter logic [31:0] BASE_ADR  = 32'd0,
  parameter int          GRID_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err_flag,
  output logic [31:0] wshb_adr,
  output logic [15:0] wshb_dat_ms,
  output logic [1:0]  wshb_sel,
  output logic        wshb_we,
  output logic        wshb_stb,
  output logic        wshb_cyc,
  output logic [2:0]  wshb_cti,
  output logic [1:0]  wshb_bte,
  input  logic        wshb_ack,
  input  logic        wshb_err
);

  localparam int XW = cnt_width(HDISP);
  localparam int YW = cnt_width(VDISP);
  localparam int BW = cnt_width(BURST_LEN);

  localparam logic [XW-1:0] X_MAX     = XW'(HDISP - 1);
  localparam logic [YW-1:0] Y_MAX     = YW'(VDISP - 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(BURST_LEN - 1);

  state_t          state;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic            last;
  logic            clr;
  logic            accept;
  logic            pix_white;
  logic [BW-1:0]   burst_cnt;

  // An err completes the beat just like an ack; the pixel is simply lost.
  assign accept = (state == WRITE) && wshb_stb && (wshb_ack || wshb_err);
  assign clr    = start && ((state == IDLE) || (state == DONE));

  pixel_scan_counter #(
    .HDISP (HDISP),
    .VDISP (VDISP),
    .XW    (XW),
    .YW    (YW)
  ) u_scan (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .inc  (accept),
    .x    (x),
    .y    (y),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wshb_cyc  <= 1'b0;
      wshb_stb  <= 1'b0;
      wshb_adr  <= BASE_ADR;
      burst_cnt <= '0;
      err_flag  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= WRITE;
            wshb_cyc  <= 1'b1;
            wshb_stb  <= 1'b1;
            wshb_adr  <= BASE_ADR;
            burst_cnt <= '0;
          end
        end
        WRITE: begin
          if (accept) begin
            if (wshb_err) err_flag <= 1'b1;
            if (last) begin
              wshb_cyc  <= 1'b0;
              wshb_stb  <= 1'b0;
              wshb_adr  <= BASE_ADR;
              burst_cnt <= '0;
`ifdef MIRE_CONTINUOUS_EN
              state     <= PAUSE;
`else
              state     <= DONE;
`endif
            end else begin
              wshb_adr <= wshb_adr + 32'd2;
              if (burst_cnt == BURST_MAX) begin
                burst_cnt <= '0;
                wshb_cyc  <= 1'b0;
                wshb_stb  <= 1'b0;
                state     <= PAUSE;
              end else begin
                burst_cnt <= burst_cnt + BW'(1);
              end
            end
          end
        end
        PAUSE: begin
          state    <= WRITE;
          wshb_cyc <= 1'b1;
          wshb_stb <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          wshb_cyc <= 1'b0;
          wshb_stb <= 1'b0;
        end
      endcase
    end
  end

  // Grid lines every 2**GRID_LOG2 pixels plus a closing border on the right and bottom edges.
  assign pix_white = on_grid(32'(x), GRID_LOG2) || on_grid(32'(y), GRID_LOG2) ||
                     (x == X_MAX) || (y == Y_MAX);

  assign wshb_dat_ms = (wshb_stb && pix_white) ? WHITE : BLACK;
  assign wshb_we     = wshb_cyc;
  assign wshb_sel    = 2'b11;
  assign wshb_cti    = CTI_CLASSIC;
  assign wshb_bte    = BTE_LINEAR;
  assign busy        = (state == WRITE) || (state == PAUSE);
  assign done        = (state == DONE);

endmodule

// File: tb/tb_mire_writer.sv
// Bench for mire_writer on an 8x2 raster, 4-beat bursts, grid pitch 4, with a randomising slave model.
// Expected addresses/pixels come from the raster rules applied to the accepted-beat index.
module tb_mire_writer;

  localparam int          H    = 8;
  localparam int          V    = 2;
  localparam int          BL   = 4;
  localparam int          G    = 2;
  localparam int          NPIX = H * V;
  localparam logic [31:0] BASE = 32'd0;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic        err_flag;
  logic [31:0] wshb_adr;
  logic [15:0] wshb_dat_ms;
  logic [1:0]  wshb_sel;
  logic        wshb_we;
  logic        wshb_stb;
  logic        wshb_cyc;
  logic [2:0]  wshb_cti;
  logic [1:0]  wshb_bte;
  logic        wshb_ack;
  logic        wshb_err;

  mire_writer #(
    .HDISP     (H),
    .VDISP     (V),
    .BURST_LEN (BL),
    .BASE_ADR  (BASE),
    .GRID_LOG2 (G)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .err_flag    (err_flag),
    .wshb_adr    (wshb_adr),
    .wshb_dat_ms (wshb_dat_ms),
    .wshb_sel    (wshb_sel),
    .wshb_we     (wshb_we),
    .wshb_stb    (wshb_stb),
    .wshb_cyc    (wshb_cyc),
    .wshb_cti    (wshb_cti),
    .wshb_bte    (wshb_bte),
    .wshb_ack    (wshb_ack),
    .wshb_err    (wshb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Slave model knobs and logs
  int          fixed_delay = 0;
  bit          rand_delay  = 0;
  bit          stray_en    = 0;
  int          err_at      = -1;
  int          err_pct     = 0;
  bit          mon_en      = 0;
  int          wait_cnt    = 0;
  int          cur_delay   = 0;
  int          hold_viol   = 0;
  logic [31:0] hold_adr;
  logic [15:0] hold_dat;
  logic [31:0] log_adr[$];
  logic [15:0] log_dat[$];
  bit          log_err[$];
  bit          tr_cyc[$];
  int          tr_n[$];
  int          gap_pos[$];
  int          gap_len[$];
  bit          done_seen;
  bit          busy_drop;
  bit          exp_err;

  function automatic int next_delay();
    return rand_delay ? int'($urandom_range(0, 3)) : fixed_delay;
  endfunction

  function automatic logic [15:0] model_pix(input int k);
    int px, py;
    px = k % H;
    py = (k / H) % V;
    return ((px % (1 << G)) == 0 || (py % (1 << G)) == 0 || px == H - 1 || py == V - 1) ?
           16'hFFFF : 16'h0000;
  endfunction

  function automatic logic [31:0] model_adr(input int k);
    return BASE + 32'(2 * (k % NPIX));
  endfunction

  // Slave: acks/errs after cur_delay wait cycles, logs each completed beat
  initial begin
    bit e;
    wshb_ack = 1'b0;
    wshb_err = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        tr_cyc.push_back(wshb_cyc);
        tr_n.push_back(log_adr.size());
        if (done === 1'b1) done_seen = 1'b1;
        if (busy !== 1'b1) busy_drop = 1'b1;
      end
      wshb_ack = 1'b0;
      wshb_err = 1'b0;
      if (!rst && wshb_stb === 1'b1) begin
        if (wait_cnt == 0) begin
          hold_adr = wshb_adr;
          hold_dat = wshb_dat_ms;
        end else if (wshb_adr !== hold_adr || wshb_dat_ms !== hold_dat) begin
          hold_viol++;
        end
        if (wait_cnt >= cur_delay) begin
          e = (log_adr.size() == err_at) || ($urandom_range(0, 99) < err_pct);
          if (e) begin
            wshb_err = 1'b1;
            wshb_ack = ($urandom_range(0, 1) == 1);
          end else begin
            wshb_ack = 1'b1;
          end
          log_adr.push_back(wshb_adr);
          log_dat.push_back(wshb_dat_ms);
          log_err.push_back(e);
          wait_cnt  = 0;
          cur_delay = next_delay();
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
        if (stray_en && !rst && $urandom_range(0, 3) == 0) wshb_ack = 1'b1;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    log_adr.delete();
    log_dat.delete();
    log_err.delete();
    tr_cyc.delete();
    tr_n.delete();
    hold_viol = 0;
    cur_delay = next_delay();
    done_seen = 1'b0;
    busy_drop = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout: done=%b required 1 within 2000 cycles", tag, done);
    end
  endtask

  // Low-cyc runs bounded by high cyc on both sides, with beats completed before each
  task automatic measure_gaps();
    int  run, pos;
    bit  seen_hi;
    gap_pos.delete();
    gap_len.delete();
    run = 0;
    pos = 0;
    seen_hi = 1'b0;
    for (int i = 0; i < tr_cyc.size(); i++) begin
      if (tr_cyc[i]) begin
        if (run > 0) begin
          gap_pos.push_back(pos);
          gap_len.push_back(run);
        end
        run = 0;
        seen_hi = 1'b1;
      end else if (seen_hi) begin
        if (run == 0) pos = tr_n[i];
        run++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({wshb_cyc, wshb_stb, wshb_we, busy, done, err_flag} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: cyc,stb,we,busy,done,err=%b required 000000",
               {wshb_cyc, wshb_stb, wshb_we, busy, done, err_flag});
    end
    checks++;
    if (wshb_adr !== BASE || wshb_dat_ms !== 16'h0000) begin
      errors++;
      $display("FAIL reset_adr_dat: adr=%h dat=%h required %h 0000", wshb_adr, wshb_dat_ms, BASE);
    end
    checks++;
    if ({wshb_sel, wshb_cti, wshb_bte} !== 7'b11_000_00) begin
      errors++;
      $display("FAIL reset_sel_cti_bte: got %b required 1100000", {wshb_sel, wshb_cti, wshb_bte});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (wshb_cyc !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start: cyc=%b busy=%b required 0 0", wshb_cyc, busy);
    end
  endtask

  task automatic test_frame();
    fixed_delay = 0; rand_delay = 0; stray_en = 0; err_at = -1; err_pct = 0;
    clear_logs();
    mon_en = 1'b1;
    pulse_start();
    checks++;
    if ({wshb_cyc, wshb_stb, wshb_we, busy} !== 4'b1111 || wshb_adr !== BASE ||
        wshb_dat_ms !== model_pix(0)) begin
      errors++;
      $display("FAIL frame_first_beat: cyc,stb,we,busy=%b adr=%h dat=%h required 1111 %h %h",
               {wshb_cyc, wshb_stb, wshb_we, busy}, wshb_adr, wshb_dat_ms, BASE, model_pix(0));
    end
    wait_done("frame");
    mon_en = 1'b0;
    checks++;
    if (log_adr.size() != NPIX) begin
      errors++;
      $display("FAIL frame_count: beats=%0d required %0d", log_adr.size(), NPIX);
    end
    for (int k = 0; k < NPIX; k++) begin
      checks++;
      if (k >= log_adr.size() || log_adr[k] !== model_adr(k) || log_dat[k] !== model_pix(k)) begin
        errors++;
        $display("FAIL frame_pix%0d: adr=%h dat=%h required %h %h", k, log_adr[k], log_dat[k],
                 model_adr(k), model_pix(k));
      end
    end
    measure_gaps();
    checks++;
    if (gap_pos.size() != (NPIX - 1) / BL) begin
      errors++;
      $display("FAIL frame_gap_count: gaps=%0d required %0d", gap_pos.size(), (NPIX - 1) / BL);
    end
    for (int j = 0; j < gap_pos.size(); j++) begin
      checks++;
      if (gap_pos[j] != BL * (j + 1) || gap_len[j] != 1) begin
        errors++;
        $display("FAIL frame_gap%0d: after=%0d len=%0d required after=%0d len=1", j, gap_pos[j],
                 gap_len[j], BL * (j + 1));
      end
    end
    checks++;
    if ({done, busy, wshb_cyc, wshb_stb, err_flag} !== 5'b10000) begin
      errors++;
      $display("FAIL frame_end: done,busy,cyc,stb,err=%b required 10000",
               {done, busy, wshb_cyc, wshb_stb, err_flag});
    end
  endtask

  task automatic test_wait_states();
    int hi;
    fixed_delay = 5; rand_delay = 0; stray_en = 0; err_at = -1; err_pct = 0;
    clear_logs();
    mon_en = 1'b1;
    pulse_start();
    wait_done("wait");
    mon_en = 1'b0;
    checks++;
    if (hold_viol != 0) begin
      errors++;
      $display("FAIL wait_hold: adr/dat changed during wait %0d times required 0", hold_viol);
    end
    hi = 0;
    foreach (tr_cyc[i]) if (tr_cyc[i]) hi++;
    checks++;
    if (hi != NPIX * 6) begin
      errors++;
      $display("FAIL wait_cyc_cycles: cyc high %0d cycles required %0d", hi, NPIX * 6);
    end
    for (int k = 0; k < NPIX; k++) begin
      checks++;
      if (k >= log_adr.size() || log_adr[k] !== model_adr(k) || log_dat[k] !== model_pix(k)) begin
        errors++;
        $display("FAIL wait_pix%0d: adr=%h dat=%h required %h %h", k, log_adr[k], log_dat[k],
                 model_adr(k), model_pix(k));
      end
    end
  endtask

  task automatic test_ignore_start();
    int n;
    fixed_delay = 1; rand_delay = 1; stray_en = 1; err_at = -1; err_pct = 0;
    clear_logs();
    mon_en = 1'b1;
    pulse_start();
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      start = (done !== 1'b1) && ($urandom_range(0, 3) == 0);
      n++;
    end
    start = 1'b0;
    mon_en = 1'b0;
    stray_en = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL ign_done_timeout: done=%b required 1", done);
    end
    checks++;
    if (log_adr.size() != NPIX) begin
      errors++;
      $display("FAIL ign_count: beats=%0d required %0d", log_adr.size(), NPIX);
    end
    for (int k = 0; k < NPIX; k++) begin
      checks++;
      if (k >= log_adr.size() || log_adr[k] !== model_adr(k) || log_dat[k] !== model_pix(k)) begin
        errors++;
        $display("FAIL ign_pix%0d: adr=%h dat=%h required %h %h", k, log_adr[k], log_dat[k],
                 model_adr(k), model_pix(k));
      end
    end
    measure_gaps();
    checks++;
    if (gap_pos.size() != (NPIX - 1) / BL) begin
      errors++;
      $display("FAIL ign_gap_count: gaps=%0d required %0d", gap_pos.size(), (NPIX - 1) / BL);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b1 || wshb_cyc !== 1'b0) begin
      errors++;
      $display("FAIL ign_done_hold: done=%b cyc=%b required 1 0", done, wshb_cyc);
    end
  endtask

  task automatic test_err();
    fixed_delay = 1; rand_delay = 0; stray_en = 0; err_at = 2; err_pct = 0;
    clear_logs();
    pulse_start();
    wait_done("err");
    err_at = -1;
    checks++;
    if (err_flag !== 1'b1) begin
      errors++;
      $display("FAIL err_flag_set: err_flag=%b required 1", err_flag);
    end
    checks++;
    if (log_adr.size() != NPIX) begin
      errors++;
      $display("FAIL err_count: beats=%0d required %0d", log_adr.size(), NPIX);
    end
    for (int k = 0; k < NPIX; k++) begin
      checks++;
      if (k >= log_adr.size() || log_adr[k] !== model_adr(k) || log_dat[k] !== model_pix(k)) begin
        errors++;
        $display("FAIL err_pix%0d: adr=%h dat=%h required %h %h", k, log_adr[k], log_dat[k],
                 model_adr(k), model_pix(k));
      end
    end
    clear_logs();
    pulse_start();
    checks++;
    if ({err_flag, done, busy} !== 3'b101) begin
      errors++;
      $display("FAIL err_restart: err,done,busy=%b required 101", {err_flag, done, busy});
    end
    wait_done("err2");
    checks++;
    if (err_flag !== 1'b1 || log_adr.size() != NPIX) begin
      errors++;
      $display("FAIL err_sticky: err_flag=%b beats=%0d required 1 %0d", err_flag,
               log_adr.size(), NPIX);
    end
  endtask

  task automatic test_rst_mid();
    int n;
    fixed_delay = 3; rand_delay = 0; stray_en = 0; err_at = -1; err_pct = 0;
    clear_logs();
    pulse_start();
    n = 0;
    while (log_adr.size() < 6 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (log_adr.size() < 6) begin
      errors++;
      $display("FAIL rst_mid_reach: beats=%0d required 6", log_adr.size());
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({wshb_cyc, wshb_stb, busy, done, err_flag} !== 5'b0 || wshb_adr !== BASE) begin
      errors++;
      $display("FAIL rst_mid_state: cyc,stb,busy,done,err=%b adr=%h required 00000 %h",
               {wshb_cyc, wshb_stb, busy, done, err_flag}, wshb_adr, BASE);
    end
    rst = 1'b0;
    fixed_delay = 0;
    clear_logs();
    pulse_start();
    wait_done("rst_mid");
    checks++;
    if (log_adr.size() != NPIX) begin
      errors++;
      $display("FAIL rst_mid_count: beats=%0d required %0d", log_adr.size(), NPIX);
    end
    for (int k = 0; k < NPIX; k++) begin
      checks++;
      if (k >= log_adr.size() || log_adr[k] !== model_adr(k) || log_dat[k] !== model_pix(k)) begin
        errors++;
        $display("FAIL rst_mid_pix%0d: adr=%h dat=%h required %h %h", k, log_adr[k], log_dat[k],
                 model_adr(k), model_pix(k));
      end
    end
  endtask

  task automatic test_random();
    exp_err = 1'b0;
    for (int f = 0; f < 3; f++) begin
      fixed_delay = 0; rand_delay = 1; stray_en = 1; err_at = -1; err_pct = 10;
      clear_logs();
      pulse_start();
      wait_done("rand");
      stray_en = 1'b0;
      err_pct = 0;
      foreach (log_err[i]) if (log_err[i]) exp_err = 1'b1;
      checks++;
      if (err_flag !== exp_err) begin
        errors++;
        $display("FAIL rand%0d_err_flag: err_flag=%b required %b", f, err_flag, exp_err);
      end
      checks++;
      if (log_adr.size() != NPIX) begin
        errors++;
        $display("FAIL rand%0d_count: beats=%0d required %0d", f, log_adr.size(), NPIX);
      end
      for (int k = 0; k < NPIX; k++) begin
        checks++;
        if (k >= log_adr.size() || log_adr[k] !== model_adr(k) || log_dat[k] !== model_pix(k)) begin
          errors++;
          $display("FAIL rand%0d_pix%0d: adr=%h dat=%h required %h %h", f, k, log_adr[k],
                   log_dat[k], model_adr(k), model_pix(k));
        end
      end
    end
  endtask

  task automatic test_continuous();
    int n;
    fixed_delay = 0; rand_delay = 1; stray_en = 0; err_at = -1; err_pct = 0;
    clear_logs();
    mon_en = 1'b1;
    pulse_start();
    done_seen = 1'b0;
    busy_drop = 1'b0;
    n = 0;
    while (log_adr.size() < 40 && n < 3000) begin
      @(negedge clk);
      start = ($urandom_range(0, 7) == 0);
      n++;
    end
    start = 1'b0;
    mon_en = 1'b0;
    checks++;
    if (log_adr.size() < 40) begin
      errors++;
      $display("FAIL cont_progress: beats=%0d required 40", log_adr.size());
    end
    for (int k = 0; k < 40; k++) begin
      checks++;
      if (k >= log_adr.size() || log_adr[k] !== model_adr(k) || log_dat[k] !== model_pix(k)) begin
        errors++;
        $display("FAIL cont_pix%0d: adr=%h dat=%h required %h %h", k, log_adr[k], log_dat[k],
                 model_adr(k), model_pix(k));
      end
    end
    checks++;
    if (done_seen || busy_drop) begin
      errors++;
      $display("FAIL cont_flags: done_seen=%b busy_drop=%b required 0 0", done_seen, busy_drop);
    end
    measure_gaps();
    checks++;
    if (gap_pos.size() < 9) begin
      errors++;
      $display("FAIL cont_gap_count: gaps=%0d required at least 9", gap_pos.size());
    end
    for (int j = 0; j < gap_pos.size(); j++) begin
      checks++;
      if (gap_pos[j] != BL * (j + 1) || gap_len[j] != 1) begin
        errors++;
        $display("FAIL cont_gap%0d: after=%0d len=%0d required after=%0d len=1", j, gap_pos[j],
                 gap_len[j], BL * (j + 1));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    test_reset();
`ifdef MIRE_CONTINUOUS_EN
    test_continuous();
`else
    test_frame();
    test_wait_states();
    test_ignore_start();
    test_err();
    test_rst_mid();
    test_random();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
